// File: rtl/ahb_pkg.sv
// Shared AHB code points and responder FSM states.
// Optional build macro: AHB_SLV_IF_ERRCHK_EN (see ahb_slv_if).
package ahb_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERR1,
    ERR2
  } state_e;

endpackage

// File: rtl/ahb_be_gen.sv
// HSIZE / HADDR[1:0] to little-endian byte enables.
// Oversized transfers map to a full word and are flagged misaligned.
module ahb_be_gen
  import ahb_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] lo_i,
  output logic [3:0] be_o,
  output logic       mis_o
);

  always_comb begin
    be_o  = 4'b1111;
    mis_o = 1'b0;
    unique case (1'b1)
      size_i == SIZE_BYTE: be_o = 4'b0001 << lo_i;
      size_i == SIZE_HALF: begin
        be_o  = lo_i[1] ? 4'b1100 : 4'b0011;
        mis_o = lo_i[0];
      end
      size_i == SIZE_WORD: mis_o = |lo_i;
      default:             mis_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_slv_if.sv
// AHB slave responder turning each data phase into one MemReq/MemAck access.
// Define AHB_SLV_IF_ERRCHK_EN to answer bad size/alignment with a 2-cycle ERROR.
module ahb_slv_if
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic [31:0]       HRDATA,
  output logic              MemReq,
  output logic              MemWr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [3:0]        MemBe,
  output logic [31:0]       MemWData,
  input  logic              MemAck,
  input  logic [31:0]       MemRData
);

  state_e state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;

  logic [3:0] be_w;
  logic       mis_w;
  logic       err_w;
  logic       accept_w;
  logic       take_w;
  logic       access_w;

  ahb_be_gen u_be (
    .size_i (HSIZE),
    .lo_i   (HADDR[1:0]),
    .be_o   (be_w),
    .mis_o  (mis_w)
  );

  assign accept_w = HSEL & HREADY & HTRANS[1];
  assign access_w = (state_q == ACCESS);

`ifdef AHB_SLV_IF_ERRCHK_EN
  assign err_w = mis_w;
  assign HRESP = (state_q == ERR1 || state_q == ERR2)
               ? RESP_ERROR : RESP_OKAY;
  logic unused_w;
  assign unused_w = ^{HBURST, HTRANS[0],
                      HADDR[31:ADDR_W+2]};
`else
  assign err_w = 1'b0;
  assign HRESP = RESP_OKAY;
  logic unused_w;
  assign unused_w = ^{HBURST, HTRANS[0], mis_w,
                      HADDR[31:ADDR_W+2]};
`endif

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    be_d      = be_q;
    take_w    = 1'b0;
    HREADYOUT = 1'b1;
    unique case (state_q)
      IDLE: take_w = accept_w;
      ACCESS: begin
        HREADYOUT = MemAck;
        if (MemAck) begin
          take_w  = accept_w;
          state_d = IDLE;
        end
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        state_d   = ERR2;
      end
      ERR2: begin
        take_w  = accept_w;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new address phase can only land once the current data phase ends.
    if (take_w) begin
      state_d = err_w ? ERR1 : ACCESS;
      wr_d    = HWRITE;
      addr_d  = HADDR[ADDR_W+1:2];
      be_d    = be_w;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
    end
  end

  assign MemReq   = access_w;
  assign MemWr    = access_w & wr_q;
  assign MemAddr  = addr_q;
  assign MemBe    = access_w ? be_q : 4'b0000;
  assign MemWData = HWDATA;
  assign HRDATA   = (access_w & ~wr_q & MemAck)
                  ? MemRData : 32'h0;

endmodule

// File: tb/tb_ahb_slv_if.sv
// Bench for ahb_slv_if: vector table, scoreboard on MemAck, corner sequences.
// Honors AHB_SLV_IF_ERRCHK_EN for the error-response sequence.
module tb_ahb_slv_if;
  import ahb_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic        MemReq;
  logic        MemWr;
  logic [15:0] MemAddr;
  logic [3:0]  MemBe;
  logic [31:0] MemWData;
  logic        MemAck;
  logic [31:0] MemRData;

  // single slave on the bus: global ready is our own ready
  assign HREADY = HREADYOUT;

  always #5 CLK = ~CLK;

  ahb_slv_if #(.ADDR_W(16)) dut (
    .CLK(CLK), .RST(RST), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .MemReq(MemReq), .MemWr(MemWr), .MemAddr(MemAddr),
    .MemBe(MemBe), .MemWData(MemWData), .MemAck(MemAck),
    .MemRData(MemRData)
  );

  typedef struct {
    logic        wr;
    logic [31:0] haddr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [15:0] eaddr;
    logic [3:0]  ebe;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int n_push = 0;
  int n_acc = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic addr_ph(input logic w, input logic [31:0] a,
                         input logic [2:0] s, input logic [1:0] t);
    HSEL   = 1'b1;
    HTRANS = t;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = s;
  endtask

  task automatic no_ph();
    HSEL   = 1'b0;
    HTRANS = TRANS_IDLE;
  endtask

  task automatic push(input logic w, input logic [15:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    exp_t e;
    e.wr = w; e.addr = a; e.be = be; e.data = d;
    sb.push_back(e);
    n_push++;
  endtask

  always @(negedge CLK) begin : mon
    exp_t e;
    if (!RST && MemReq && MemAck) begin
      n_acc++;
      if (sb.size() == 0) begin
        chk("sb_unexpected_access", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("MemAddr", 32'(MemAddr), 32'(e.addr));
        chk("MemBe", 32'(MemBe), 32'(e.be));
        chk("MemWr", 32'(MemWr), 32'(e.wr));
        if (e.wr) chk("MemWData", MemWData, e.data);
        else      chk("HRDATA", HRDATA, e.data);
      end
    end
  end

  logic [31:0] bd [4];

  initial begin
    RST = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = TRANS_IDLE;
    HWRITE = 1'b0; HSIZE = SIZE_BYTE; HBURST = 3'b000;
    HWDATA = '0; MemAck = 1'b0; MemRData = '0;

    tbl.push_back('{1'b1, 32'h0000_0010, SIZE_WORD, 32'hDEADBEEF, 16'h0004, 4'b1111});
    tbl.push_back('{1'b0, 32'h0000_0008, SIZE_WORD, 32'h12345678, 16'h0002, 4'b1111});
    tbl.push_back('{1'b1, 32'h0000_0003, SIZE_BYTE, 32'hA5A5A5A5, 16'h0000, 4'b1000});
    tbl.push_back('{1'b1, 32'h0000_0002, SIZE_HALF, 32'h0BAD0000, 16'h0000, 4'b1100});
    tbl.push_back('{1'b0, 32'h0000_1001, SIZE_BYTE, 32'h0000_7700, 16'h0400, 4'b0010});
    tbl.push_back('{1'b1, 32'h0003_FFFC, SIZE_WORD, 32'hFFFF_0001, 16'hFFFF, 4'b1111});
    tbl.push_back('{1'b0, 32'h0005_0006, SIZE_HALF, 32'h5A5A_0000, 16'h4001, 4'b1100});
`ifndef AHB_SLV_IF_ERRCHK_EN
    tbl.push_back('{1'b1, 32'h0000_0002, SIZE_WORD, 32'h1111_2222, 16'h0000, 4'b1111});
    tbl.push_back('{1'b0, 32'h0000_000C, 3'b011,    32'h3333_4444, 16'h0003, 4'b1111});
    tbl.push_back('{1'b1, 32'h0000_0001, SIZE_HALF, 32'h5555_6666, 16'h0000, 4'b0011});
`endif

    repeat (2) @(posedge CLK);
    smp();
    chk("rst_rdy", 32'(HREADYOUT), 32'd1);
    chk("rst_resp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_req", 32'(MemReq), 32'd0);
    chk("rst_wr", 32'(MemWr), 32'd0);
    chk("rst_addr", 32'(MemAddr), 32'd0);
    chk("rst_be", 32'(MemBe), 32'd0);
    nxt();
    RST = 1'b0;

    foreach (tbl[i]) begin
      nxt();
      addr_ph(tbl[i].wr, tbl[i].haddr, tbl[i].size, TRANS_NONSEQ);
      MemAck = 1'b0;
      push(tbl[i].wr, tbl[i].eaddr, tbl[i].ebe, tbl[i].data);
      smp();
      chk("ap_rdy", 32'(HREADYOUT), 32'd1);
      chk("ap_req", 32'(MemReq), 32'd0);
      nxt();
      no_ph();
      MemAck   = 1'b1;
      HWDATA   = tbl[i].wr ? tbl[i].data : 32'hC0DE_C0DE;
      MemRData = tbl[i].wr ? 32'hBAD0_BAD0 : tbl[i].data;
      smp();
      chk("dp_rdy", 32'(HREADYOUT), 32'd1);
      chk("dp_req", 32'(MemReq), 32'd1);
      chk("dp_resp", 32'(HRESP), 32'd0);
      if (tbl[i].wr) chk("wr_hrdata_zero", HRDATA, 32'd0);
    end
    nxt();
    MemAck = 1'b0;

    // read with three wait states
    nxt();
    addr_ph(1'b0, 32'h0000_0008, SIZE_WORD, TRANS_NONSEQ);
    push(1'b0, 16'h0002, 4'b1111, 32'h12345678);
    smp();
    for (int w = 0; w < 3; w++) begin
      nxt();
      no_ph();
      MemAck = 1'b0;
      MemRData = 32'hFFFF_FFFF;
      smp();
      chk("wait_req", 32'(MemReq), 32'd1);
      chk("wait_rdy", 32'(HREADYOUT), 32'd0);
      chk("wait_hrdata", HRDATA, 32'd0);
    end
    nxt();
    MemAck = 1'b1;
    MemRData = 32'h12345678;
    smp();
    chk("wait_done_rdy", 32'(HREADYOUT), 32'd1);
    nxt();
    MemAck = 1'b0;
    smp();
    chk("wait_after_req", 32'(MemReq), 32'd0);

    // INCR4 back-to-back zero-wait writes
    bd[0] = 32'h0101_0101; bd[1] = 32'h0202_0202;
    bd[2] = 32'h0303_0303; bd[3] = 32'h0404_0404;
    HBURST = 3'b011;
    nxt();
    addr_ph(1'b1, 32'h20, SIZE_WORD, TRANS_NONSEQ);
    push(1'b1, 16'd8, 4'b1111, bd[0]);
    smp();
    for (int b = 1; b <= 4; b++) begin
      nxt();
      if (b < 4) begin
        addr_ph(1'b1, 32'h20 + 32'(4 * b), SIZE_WORD, TRANS_SEQ);
        push(1'b1, 16'(8 + b), 4'b1111, bd[b]);
      end else begin
        no_ph();
      end
      HWDATA = bd[b-1];
      MemAck = 1'b1;
      smp();
      chk("burst_req", 32'(MemReq), 32'd1);
      chk("burst_rdy", 32'(HREADYOUT), 32'd1);
    end
    nxt();
    MemAck = 1'b0;
    HBURST = 3'b000;
    smp();
    chk("burst_end_req", 32'(MemReq), 32'd0);

    // reset in the middle of an unacknowledged access
    nxt();
    addr_ph(1'b1, 32'h40, SIZE_WORD, TRANS_NONSEQ);
    smp();
    nxt();
    no_ph();
    smp();
    chk("pre_rst_req", 32'(MemReq), 32'd1);
    chk("pre_rst_rdy", 32'(HREADYOUT), 32'd0);
    nxt();
    RST = 1'b1;
    smp();
    chk("rst_sync_req", 32'(MemReq), 32'd1);
    nxt();
    RST = 1'b0;
    smp();
    chk("post_rst_req", 32'(MemReq), 32'd0);
    chk("post_rst_rdy", 32'(HREADYOUT), 32'd1);
    chk("post_rst_resp", 32'(HRESP), 32'd0);
    chk("post_rst_hrdata", HRDATA, 32'd0);
    chk("post_rst_be", 32'(MemBe), 32'd0);

    // BUSY gives a zero-wait OKAY; a stray MemAck is ignored
    nxt();
    addr_ph(1'b1, 32'h50, SIZE_WORD, TRANS_BUSY);
    smp();
    chk("busy_ap_rdy", 32'(HREADYOUT), 32'd1);
    nxt();
    no_ph();
    MemAck = 1'b1;
    smp();
    chk("busy_req", 32'(MemReq), 32'd0);
    chk("busy_rdy", 32'(HREADYOUT), 32'd1);
    chk("busy_resp", 32'(HRESP), 32'd0);
    nxt();
    MemAck = 1'b0;
    smp();
    chk("stray_ack_req", 32'(MemReq), 32'd0);

`ifdef AHB_SLV_IF_ERRCHK_EN
    nxt();
    addr_ph(1'b1, 32'h02, SIZE_WORD, TRANS_NONSEQ);
    smp();
    nxt();
    no_ph();
    smp();
    chk("err1_req", 32'(MemReq), 32'd0);
    chk("err1_rdy", 32'(HREADYOUT), 32'd0);
    chk("err1_resp", 32'(HRESP), 32'd1);
    nxt();
    addr_ph(1'b0, 32'h44, SIZE_WORD, TRANS_NONSEQ);
    push(1'b0, 16'h0011, 4'b1111, 32'hCAFE_F00D);
    smp();
    chk("err2_req", 32'(MemReq), 32'd0);
    chk("err2_rdy", 32'(HREADYOUT), 32'd1);
    chk("err2_resp", 32'(HRESP), 32'd1);
    nxt();
    no_ph();
    MemAck = 1'b1;
    MemRData = 32'hCAFE_F00D;
    smp();
    chk("after_err_req", 32'(MemReq), 32'd1);
    chk("after_err_resp", 32'(HRESP), 32'd0);
    nxt();
    MemAck = 1'b0;
    smp();
`endif

    nxt();
    chk("sb_left", 32'(sb.size()), 32'd0);
    chk("acc_count", 32'(n_acc), 32'(n_push));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
